alu_op_sequencer: RTL

- Control and operand stage directly upstream of the per-bit 8-to-1 result multiplexer bank in the 32-bit ALU.
- Accepts one ALU command per transaction through a valid/ready handshake and holds the operands for the function units.
- Drives the 3-bit result select for the whole transaction and runs the iterative left shift that feeds mux input 7.
- Captures the selected mux result, computes a zero flag and presents both through an output valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Control and operand stage feeding the per-bit 8:1 result mux bank of the ALU.
// Accepts one command per transaction, holds select/operands stable for the
// function units, runs the iterative left shift for mux input 7, then captures
// the mux result and a zero flag and offers them on an output handshake.
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic [2:0]         sel,
  output logic [WIDTH-1:0]   opa_q,
  output logic [WIDTH-1:0]   opb_q,
  output logic [WIDTH-1:0]   shift_q,
  input  logic [WIDTH-1:0]   alu_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EXEC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic               accept;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; only IDLE accepts, only DONE presents.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_op == OP_SLL && in_shamt != '0) begin
            state_nxt = SHIFT;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select and operands are latched at accept and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (accept) begin
      sel   <= in_op;
      opa_q <= in_a;
      opb_q <= in_b;
    end
  end

  // Iterative shifter: loads A at accept, then one zero-filled step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt     <= '0;
    end else if (accept) begin
      shift_q <= in_a;
      cnt     <= in_shamt;
    end else if (state == SHIFT) begin
      shift_q <= shift_q << 1;
      cnt     <= cnt - SHAMT_W'(1);
    end
  end

  // Capture the mux bank output in EXEC, when select and operands have settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
    end else if (state == EXEC) begin
      result <= alu_res;
      zero   <= (alu_res == '0);
    end
  end

endmodule
